// File: rtl/div_pkg.sv
// Shared encodings and widths for the multi-cycle divider.
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Magnitude of an operand; 0x80000000 wraps to itself.
  function automatic logic [REG_BUS-1:0] abs_op(input logic          sgn,
                                                input logic [REG_BUS-1:0] v);
    return (sgn && v[REG_BUS-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Restoring 32-bit divider for DIV/DIVU: one quotient bit per cycle,
// result returned as {remainder, quotient} with a registered ready flag.
module div import div_pkg::*; (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o,
  output div_state_t                state_o
);

  // Handshake: start_i is held high by EX until it sees ready_o; EX then drops
  // start_i, ready_o/result_o clear on the next edge, and a new start_i is
  // accepted from the edge after that. annul_i beats start_i in every state.

  div_state_t                r_state;
  logic [5:0]                r_cnt;
  logic [DOUBLE_REG_BUS-1:0] r_work;
  logic [REG_BUS-1:0]        r_divisor;
  logic                      r_neg_quo;
  logic                      r_neg_rem;
  logic                      r_ready;
  logic [DOUBLE_REG_BUS-1:0] r_result;

  logic [REG_BUS:0]   w_partial;
  logic [REG_BUS+1:0] w_trial;
  logic               w_keep;
  logic               w_unused_carry;
  logic [REG_BUS-1:0] w_quo_fix;
  logic [REG_BUS-1:0] w_rem_fix;

  // r_work = {partial remainder, dividend bits still to consume / quotient bits}
  assign w_partial      = r_work[DOUBLE_REG_BUS-1:REG_BUS-1];
  assign w_trial        = {1'b0, w_partial} - {2'b00, r_divisor};
  assign w_keep         = ~w_trial[REG_BUS+1];
  // A kept difference is below the divisor, so bit 32 is always zero.
  assign w_unused_carry = w_trial[REG_BUS];

  assign w_quo_fix = r_neg_quo ? (~r_work[REG_BUS-1:0] + 32'd1)
                               : r_work[REG_BUS-1:0];
  assign w_rem_fix = r_neg_rem ? (~r_work[DOUBLE_REG_BUS-1:REG_BUS] + 32'd1)
                               : r_work[DOUBLE_REG_BUS-1:REG_BUS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= 6'd0;
      r_work    <= '0;
      r_divisor <= ZERO_WORD;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_ready   <= DIV_RESULT_NOT_READY;
      r_result  <= '0;
    end else begin
      case (r_state)
        DIV_FREE: begin
          r_ready  <= DIV_RESULT_NOT_READY;
          r_result <= '0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == ZERO_WORD) begin
              r_state <= DIV_BY_ZERO;
            end else begin
              r_state   <= DIV_ON;
              r_cnt     <= 6'd0;
              r_work    <= {ZERO_WORD, abs_op(signed_div_i, opdata1_i)};
              r_divisor <= abs_op(signed_div_i, opdata2_i);
              r_neg_quo <= signed_div_i & (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
              r_neg_rem <= signed_div_i & opdata1_i[REG_BUS-1];
            end
          end
        end
        DIV_BY_ZERO: begin
          if (annul_i) begin
            r_state <= DIV_FREE;
          end else begin
            r_work  <= '0;
            r_state <= DIV_END;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            r_state  <= DIV_FREE;
            r_cnt    <= 6'd0;
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= '0;
          end else if (r_cnt != 6'd32) begin
            if (w_keep)
              r_work <= {w_trial[REG_BUS-1:0], r_work[REG_BUS-2:0], 1'b1};
            else
              r_work <= {r_work[DOUBLE_REG_BUS-2:0], 1'b0};
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_work  <= {w_rem_fix, w_quo_fix};
            r_state <= DIV_END;
          end
        end
        DIV_END: begin
          if (annul_i || start_i == DIV_STOP) begin
            r_state  <= DIV_FREE;
            r_cnt    <= 6'd0;
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= '0;
          end else begin
            r_ready  <= DIV_RESULT_READY;
            r_result <= r_work;
          end
        end
        default: r_state <= DIV_FREE;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign state_o  = r_state;

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for the restoring divider: latency, signed/unsigned
// results, divide-by-zero, annul, mid-run reset and held results.
module tb_div;
  import div_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  div_state_t  state_o;

  int checks;
  int errors;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge. Operands are scrambled after the start edge so the
  // latched copies must be used. Samples ready one cycle before it is due,
  // when due, and one cycle after start_i is dropped.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic rdy_early, output logic rdy, output logic [63:0] res,
                         output logic rdy_after, output logic [63:0] res_after);
    int lat;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat = (b == 32'd0) ? 2 : 34;
    @(posedge clk);
    #1;
    opdata1_i    = ~a;
    opdata2_i    = 32'd0;
    signed_div_i = ~sgn;
    repeat (lat - 1) @(posedge clk);
    @(negedge clk);
    rdy_early = ready_o;
    @(posedge clk);
    @(negedge clk);
    rdy     = ready_o;
    res     = result_o;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rdy_after = ready_o;
    res_after = result_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'h1234_5678; opdata2_i = 32'h0000_0003;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++;
    if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
    checks++;
    if (state_o !== DIV_FREE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, DIV_FREE); end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    vec_t vecs[10];
    logic re, r, ra;
    logic [63:0] res, resa;
    vecs[0] = '{1'b0, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
    vecs[4] = '{1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0000};
    vecs[5] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    vecs[6] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h0000_0003, 64'h0000_0002_2AAA_AAAA};
    vecs[8] = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 64'h0000_0001_7FFF_FFFC};
    vecs[9] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'h7FFF_FFFF_0000_0000};
    // Consecutive calls start exactly 36 cycles apart.
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, re, r, res, ra, resa);
      checks++;
      if (re !== 1'b0) begin errors++; $display("FAIL arith%0d_early_ready: got %b expected 0", i, re); end
      checks++;
      if (r !== 1'b1) begin errors++; $display("FAIL arith%0d_ready: got %b expected 1", i, r); end
      checks++;
      if (res !== vecs[i].exp) begin errors++; $display("FAIL arith%0d_result: got %h expected %h", i, res, vecs[i].exp); end
      checks++;
      if (ra !== 1'b0 || resa !== 64'd0) begin
        errors++; $display("FAIL arith%0d_release: got ready %b result %h expected 0/0", i, ra, resa);
      end
    end
    checks++;
    if (state_o !== DIV_FREE) begin errors++; $display("FAIL arith_final_state: got %0d expected %0d", state_o, DIV_FREE); end
  endtask

  task automatic test_div_by_zero();
    logic re, r, ra;
    logic [63:0] res, resa;
    logic [31:0] dvd[2];
    dvd[0] = 32'h0000_0005;
    dvd[1] = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      run_div(i[0], dvd[i], 32'd0, re, r, res, ra, resa);
      checks++;
      if (re !== 1'b0) begin errors++; $display("FAIL dbz%0d_early_ready: got %b expected 0", i, re); end
      checks++;
      if (r !== 1'b1) begin errors++; $display("FAIL dbz%0d_ready: got %b expected 1", i, r); end
      checks++;
      if (res !== 64'd0) begin errors++; $display("FAIL dbz%0d_result: got %h expected 0", i, res); end
      checks++;
      if (ra !== 1'b0) begin errors++; $display("FAIL dbz%0d_release: got %b expected 0", i, ra); end
    end
  endtask

  task automatic test_annul();
    logic seen_ready;
    logic re, r, ra;
    logic [63:0] res, resa;
    signed_div_i = 1'b0; opdata1_i = 32'h1234_5678; opdata2_i = 32'h0000_0003; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    checks++;
    if (state_o !== DIV_FREE) begin errors++; $display("FAIL annul_on_state: got %0d expected %0d", state_o, DIV_FREE); end
    seen_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen_ready = 1'b1;
    end
    checks++;
    if (seen_ready !== 1'b0) begin errors++; $display("FAIL annul_on_no_ready: got %b expected 0", seen_ready); end
    run_div(1'b1, 32'd100, 32'd7, re, r, res, ra, resa);
    checks++;
    if (r !== 1'b1 || res !== 64'h0000_0002_0000_000E) begin
      errors++; $display("FAIL annul_fresh_100_7: got ready %b result %h expected 1/00000002_0000000e", r, res);
    end
    // Annul while the result is presented, with start_i still high.
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (34) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || result_o !== 64'h0000_0000_0000_0003) begin
      errors++; $display("FAIL annul_end_pre: got ready %b result %h expected 1/00000000_00000003", ready_o, result_o);
    end
    annul_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || state_o !== DIV_FREE) begin
      errors++; $display("FAIL annul_end_clear: got ready %b result %h state %0d expected 0/0/%0d", ready_o, result_o, state_o, DIV_FREE);
    end
  endtask

  task automatic test_reset_mid();
    signed_div_i = 1'b0; opdata1_i = 32'h0000_FFFF; opdata2_i = 32'h0000_0010; start_i = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got ready %b result %h expected 0/0", ready_o, result_o);
    end
    checks++;
    if (state_o !== DIV_FREE) begin errors++; $display("FAIL rst_mid_state: got %0d expected %0d", state_o, DIV_FREE); end
  endtask

  task automatic test_hold();
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd10; start_i = 1'b1;
    @(posedge clk);
    #1 opdata1_i = 32'd5;
    repeat (34) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || result_o !== 64'h0000_0000_0000_0064) begin
      errors++; $display("FAIL hold_first: got ready %b result %h expected 1/00000000_00000064", ready_o, result_o);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1 || result_o !== 64'h0000_0000_0000_0064 || state_o !== DIV_END) begin
        errors++; $display("FAIL hold_cycle%0d: got ready %b result %h state %0d expected 1/00000000_00000064/%0d",
                           k, ready_o, result_o, state_o, DIV_END);
      end
    end
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL hold_release: got ready %b result %h expected 0/0", ready_o, result_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_div_by_zero();
    test_annul();
    test_reset_mid();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
